serial_operand_serializer_msb_first: RTL and testbench

//  Upstream feeder for the MSB-first serial comparator.
//  - Accepts a pair of parallel WIDTH-bit operands (A, B) on a valid/ready handshake.
//  - Emits them bit-serially, MSB first, one bit pair per clock.
//  - Drives cmp_rst, a synchronous clear for the comparator, one cycle before the first bit.
//  - Flags first/last so the consumer knows when the compare result is final.
//

---
 rtl/serial_cmp_pkg.sv | 17 +
 rtl/msb_first_shift_reg.sv | 33 +++
 rtl/serial_operand_serializer_msb_first.sv | 154 +++++++++++++++
 tb/tb_serial_operand_serializer_msb_first.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the MSB-first serial operand path.
//   ser_state_t : serializer FSM encoding (IDLE -> LOAD -> SHIFT)
//   cnt_w()     : bit-counter width for a given operand width (min 1 bit)
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } ser_state_t;

  // A WIDTH of 1 still needs a 1-bit counter so the port/regs stay legal.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/msb_first_shift_reg.sv
// Parallel-load, left-shifting register presenting its MSB.
//   clk, rst_n : clock, async active-low reset (register clears to 0)
//   load       : capture load_data (wins over shift_en)
//   shift_en   : shift left by one, zero fill
//   load_data  : parallel operand
//   msb_out    : current MSB (combinational view of the register)
module msb_first_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb_out
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift_en) begin
      // Shift operator rather than a slice keeps WIDTH=1 legal.
      sr <= sr << 1;
    end
  end

  assign msb_out = sr[WIDTH-1];

endmodule

// File: rtl/serial_operand_serializer_msb_first.sv
// Feeds an MSB-first serial comparator from a parallel operand pair.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake
//   in_a, in_b          : parallel operands, sampled only on the handshake
//   cmp_rst             : one-cycle synchronous clear for the comparator
//   a_bit, b_bit        : serial operand bits, MSB first
//   bit_valid           : a_bit/b_bit carry operand bits this cycle
//   first, last         : MSB / LSB markers (last = comparator result final)
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both 1. in_ready is registered and does not depend on in_valid; in_valid
// while in_ready is 0 is simply ignored (no buffering). in_ready is high in
// IDLE and in the LSB cycle of SHIFT, which allows back-to-back words with a
// single LOAD cycle between them.
//
// Every output is registered: the combinational block computes the next
// state/counter and from those the values the outputs must show next cycle.
module serial_operand_serializer_msb_first
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_rst,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             first,
  output logic             last
);

  localparam int            CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  ser_state_t    state;
  ser_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic hs;
  logic load_sr;
  logic shift_en;
  logic a_msb;
  logic b_msb;

  logic in_ready_d;
  logic cmp_rst_d;
  logic a_bit_d;
  logic b_bit_d;
  logic bit_valid_d;
  logic first_d;
  logic last_d;

  assign hs = in_valid & in_ready;

  msb_first_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_sr),
    .shift_en  (shift_en),
    .load_data (in_a),
    .msb_out   (a_msb)
  );

  msb_first_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_sr),
    .shift_en  (shift_en),
    .load_data (in_b),
    .msb_out   (b_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_sr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          state_nxt = ST_LOAD;
          load_sr   = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_SHIFT;
        cnt_nxt   = CNT_MAX;
      end
      ST_SHIFT: begin
        if (cnt == '0) begin
          if (hs) begin
            state_nxt = ST_LOAD;
            load_sr   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // The register MSB is sampled into a_bit/b_bit on the same edge that
    // shifts it away, so the registered bit lines up with cnt.
    shift_en    = (state_nxt == ST_SHIFT);
    bit_valid_d = shift_en;
    a_bit_d     = shift_en & a_msb;
    b_bit_d     = shift_en & b_msb;
    first_d     = shift_en && (cnt_nxt == CNT_MAX);
    last_d      = shift_en && (cnt_nxt == '0);
    in_ready_d  = (state_nxt == ST_IDLE) || last_d;
    cmp_rst_d   = (state_nxt == ST_LOAD);
  end

  // Reset holds the comparator in clear while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      cmp_rst   <= 1'b1;
      a_bit     <= 1'b0;
      b_bit     <= 1'b0;
      bit_valid <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      cmp_rst   <= cmp_rst_d;
      a_bit     <= a_bit_d;
      b_bit     <= b_bit_d;
      bit_valid <= bit_valid_d;
      first     <= first_d;
      last      <= last_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer_msb_first.sv
// Directed bench for the MSB-first operand serializer (WIDTH=8 and WIDTH=1
// instances). A behavioural MSB-first comparator turns the serial stream
// into greater/less/equal results that are checked against hand values.
module tb_serial_operand_serializer_msb_first;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic       in_valid8, in_ready8;
  logic [7:0] in_a8, in_b8;
  logic       cmp_rst8, a_bit8, b_bit8, bit_valid8, first8, last8;

  serial_operand_serializer_msb_first #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .cmp_rst   (cmp_rst8),
    .a_bit     (a_bit8),
    .b_bit     (b_bit8),
    .bit_valid (bit_valid8),
    .first     (first8),
    .last      (last8)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic       in_valid1, in_ready1;
  logic [0:0] in_a1, in_b1;
  logic       cmp_rst1, a_bit1, b_bit1, bit_valid1, first1, last1;

  serial_operand_serializer_msb_first #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .cmp_rst   (cmp_rst1),
    .a_bit     (a_bit1),
    .b_bit     (b_bit1),
    .bit_valid (bit_valid1),
    .first     (first1),
    .last      (last1)
  );

  // ---------------- comparator model ----------------
  // res encoding: 0 = equal, 1 = A greater, 2 = A less. The current bit is
  // folded in combinationally so the result is final during the last cycle.
  logic       m8_eq, m8_gt, m8_lt, m1_eq, m1_gt, m1_lt;
  logic [1:0] res8, res1;

  always @(posedge clk) begin
    if (cmp_rst8) begin
      m8_eq <= 1'b1; m8_gt <= 1'b0; m8_lt <= 1'b0;
    end else if (bit_valid8 && m8_eq && (a_bit8 != b_bit8)) begin
      m8_eq <= 1'b0; m8_gt <= a_bit8; m8_lt <= b_bit8;
    end
  end

  always @(posedge clk) begin
    if (cmp_rst1) begin
      m1_eq <= 1'b1; m1_gt <= 1'b0; m1_lt <= 1'b0;
    end else if (bit_valid1 && m1_eq && (a_bit1 != b_bit1)) begin
      m1_eq <= 1'b0; m1_gt <= a_bit1; m1_lt <= b_bit1;
    end
  end

  always_comb begin
    res8 = 2'd0;
    if (m8_gt || (m8_eq && bit_valid8 && a_bit8 && !b_bit8)) res8 = 2'd1;
    else if (m8_lt || (m8_eq && bit_valid8 && !a_bit8 && b_bit8)) res8 = 2'd2;
    res1 = 2'd0;
    if (m1_gt || (m1_eq && bit_valid1 && a_bit1 && !b_bit1)) res1 = 2'd1;
    else if (m1_lt || (m1_eq && bit_valid1 && !a_bit1 && b_bit1)) res1 = 2'd2;
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input string tag);
    in_valid8 = 1'b1;
    in_a8     = a;
    in_b8     = b;
    check({tag, " in_ready@hs"}, in_ready8, 1);
    tick();
  endtask

  // Entered in the LOAD cycle; returns in the LSB cycle. nv/na/nb are driven
  // from LOAD on (changing in_a/in_b mid-word must have no effect).
  task automatic word8(input logic [7:0] a, input logic [7:0] b,
                       input logic nv, input logic [7:0] na, input logic [7:0] nb,
                       input int from, input logic [1:0] exp_res, input string tag);
    check({tag, " load cmp_rst"},   cmp_rst8, 1);
    check({tag, " load bit_valid"}, bit_valid8, 0);
    check({tag, " load in_ready"},  in_ready8, 0);
    check({tag, " load bits"},      {a_bit8, b_bit8}, 0);
    in_valid8 = nv;
    in_a8     = na;
    in_b8     = nb;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s bit%0d a", tag, i),         a_bit8, a[7-i]);
      check($sformatf("%s bit%0d b", tag, i),         b_bit8, b[7-i]);
      check($sformatf("%s bit%0d valid", tag, i),     bit_valid8, 1);
      check($sformatf("%s bit%0d first", tag, i),     first8, (i == 0));
      check($sformatf("%s bit%0d last", tag, i),      last8, (i == 7));
      check($sformatf("%s bit%0d in_ready", tag, i),  in_ready8, (i == 7));
      check($sformatf("%s bit%0d cmp_rst", tag, i),   cmp_rst8, 0);
      if (i >= from) check($sformatf("%s bit%0d result", tag, i), res8, exp_res);
      if (i < 7) tick();
    end
  endtask

  task automatic check_idle8(input string tag, input logic [1:0] exp_res);
    check({tag, " idle bit_valid"}, bit_valid8, 0);
    check({tag, " idle in_ready"},  in_ready8, 1);
    check({tag, " idle cmp_rst"},   cmp_rst8, 0);
    check({tag, " idle bits"},      {a_bit8, b_bit8, first8, last8}, 0);
    check({tag, " idle result"},    res8, exp_res);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic       pa1 [3];
  logic       pb1 [3];
  logic [1:0] pr1 [3];

  initial begin
    rst_n     = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0;

    // 1. reset and release with no traffic
    repeat (2) @(posedge clk);
    #1;
    check("rst cmp_rst8",   cmp_rst8, 1);
    check("rst in_ready8",  in_ready8, 0);
    check("rst outs8",      {a_bit8, b_bit8, bit_valid8, first8, last8}, 0);
    check("rst cmp_rst1",   cmp_rst1, 1);
    check("rst in_ready1",  in_ready1, 0);
    rst_n = 1'b1;
    tick();
    check("rel in_ready8", in_ready8, 1);
    check("rel cmp_rst8",  cmp_rst8, 0);
    check("rel in_ready1", in_ready1, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("quiet%0d bit_valid", i), bit_valid8, 0);
      tick();
    end

    // 2. single pair A5 vs A4 (decided at LSB)
    start8(8'hA5, 8'hA4, "t2");
    word8(8'hA5, 8'hA4, 1'b0, 8'hFF, 8'h00, 7, 2'd1, "t2");
    tick();
    check_idle8("t2", 2'd1);
    tick();
    check_idle8("t2 hold", 2'd1);

    // 3. back-to-back (3C,3C) then (00,FF), in_valid held high
    start8(8'h3C, 8'h3C, "t3a");
    word8(8'h3C, 8'h3C, 1'b1, 8'h00, 8'hFF, 0, 2'd0, "t3a");
    tick();
    word8(8'h00, 8'hFF, 1'b0, 8'h55, 8'h55, 0, 2'd2, "t3b");
    tick();
    check_idle8("t3b", 2'd2);

    // 4. early decision 80 vs 7F
    start8(8'h80, 8'h7F, "t4");
    word8(8'h80, 8'h7F, 1'b0, 8'h00, 8'h00, 0, 2'd1, "t4");
    tick();
    check_idle8("t4", 2'd1);

    // 5. reset in the 4th SHIFT cycle of F0 vs 0F
    start8(8'hF0, 8'h0F, "t5");
    check("t5 load cmp_rst", cmp_rst8, 1);
    in_valid8 = 1'b0;
    repeat (4) tick();
    check("t5 pre-rst a_bit",     a_bit8, 1);
    check("t5 pre-rst bit_valid", bit_valid8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async cmp_rst",  cmp_rst8, 1);
    check("t5 async in_ready", in_ready8, 0);
    check("t5 async outs",     {a_bit8, b_bit8, bit_valid8, first8, last8}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t5 held last", last8, 0);
    rst_n = 1'b1;
    tick();
    check("t5 rel in_ready",  in_ready8, 1);
    check("t5 rel bit_valid", bit_valid8, 0);
    start8(8'h01, 8'h02, "t5b");
    word8(8'h01, 8'h02, 1'b0, 8'h00, 8'h00, 6, 2'd2, "t5b");
    tick();
    check_idle8("t5b", 2'd2);

    // 6. WIDTH=1: (1,0) (0,1) (1,1) back-to-back
    pa1 = '{1'b1, 1'b0, 1'b1};
    pb1 = '{1'b0, 1'b1, 1'b1};
    pr1 = '{2'd1, 2'd2, 2'd0};
    in_valid1 = 1'b1;
    in_a1     = pa1[0];
    in_b1     = pb1[0];
    check("w1 in_ready@hs", in_ready1, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w1 p%0d load cmp_rst", k),   cmp_rst1, 1);
      check($sformatf("w1 p%0d load valid", k),     bit_valid1, 0);
      check($sformatf("w1 p%0d load in_ready", k),  in_ready1, 0);
      if (k < 2) begin
        in_a1 = pa1[k+1];
        in_b1 = pb1[k+1];
      end else begin
        in_valid1 = 1'b0;
      end
      tick();
      check($sformatf("w1 p%0d valid", k),    bit_valid1, 1);
      check($sformatf("w1 p%0d first", k),    first1, 1);
      check($sformatf("w1 p%0d last", k),     last1, 1);
      check($sformatf("w1 p%0d a", k),        a_bit1, pa1[k]);
      check($sformatf("w1 p%0d b", k),        b_bit1, pb1[k]);
      check($sformatf("w1 p%0d in_ready", k), in_ready1, 1);
      check($sformatf("w1 p%0d result", k),   res1, pr1[k]);
      tick();
    end
    check("w1 idle in_ready",  in_ready1, 1);
    check("w1 idle bit_valid", bit_valid1, 0);
    check("w1 idle cmp_rst",   cmp_rst1, 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
